// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/compare/shift ops, plus iterative
// shift-add multiply and restoring divide that retire one bit per cycle.
// Handshake: request accepted in IDLE, result held in DONE until taken.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             bool,
    output logic             op_err
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_AND    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_XOR    = 5'h04;
    localparam logic [4:0] OP_SLL    = 5'h05;
    localparam logic [4:0] OP_SRL    = 5'h06;
    localparam logic [4:0] OP_SRA    = 5'h07;
    localparam logic [4:0] OP_BEQ    = 5'h08;
    localparam logic [4:0] OP_BNE    = 5'h09;
    localparam logic [4:0] OP_BGE    = 5'h0A;
    localparam logic [4:0] OP_BLT    = 5'h0B;
    localparam logic [4:0] OP_SLT    = 5'h0C;
    localparam logic [4:0] OP_SLTU   = 5'h0D;
    localparam logic [4:0] OP_MUL    = 5'h0E;
    localparam logic [4:0] OP_MULH   = 5'h0F;
    localparam logic [4:0] OP_MULHSU = 5'h10;
    localparam logic [4:0] OP_MULHU  = 5'h11;
    localparam logic [4:0] OP_DIV    = 5'h12;
    localparam logic [4:0] OP_DIVU   = 5'h13;
    localparam logic [4:0] OP_REM    = 5'h14;
    localparam logic [4:0] OP_REMU   = 5'h15;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, next_state;

    // Control registers (reset)
    logic [CW-1:0]      cnt;

    // Iteration datapath registers (no reset; loaded on every accept)
    logic [4:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic               b_zero;
    logic               neg_res;
    logic               neg_rem;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;

    logic               accept;
    logic               is_multi;
    logic               last_iter;
    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH:0]     simple_res;

    // Single-cycle operations; returns {bool, result}. Unknown codes act as ADD.
    function automatic logic [WIDTH:0] simple_op(input logic [4:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHW-1:0]          shamt;
        logic [WIDTH-1:0]        r;
        logic                    flag;
        sa    = a;
        sb    = b;
        shamt = b[SHW-1:0];
        r     = '0;
        flag  = 1'b0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << shamt;
            OP_SRL:  r = a >> shamt;
            OP_SRA:  r = sa >>> shamt;
            OP_BEQ:  flag = (a == b);
            OP_BNE:  flag = (a != b);
            OP_BGE:  flag = (sa >= sb);
            OP_BLT:  flag = (sa < sb);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            default: r = a + b;
        endcase
        return {flag, r};
    endfunction

    // Magnitude of an operand when it is interpreted as signed.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic signed_in);
        return (signed_in && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // Final sign correction and selection for multiply/divide results.
    function automatic logic [WIDTH-1:0] finish_op(input logic [4:0] op,
                                                   input logic [2*WIDTH-1:0] p,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] r,
                                                   input logic nres,
                                                   input logic nrem,
                                                   input logic bz,
                                                   input logic [WIDTH-1:0] a);
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   res;
        prod = nres ? (~p + 1'b1) : p;
        res  = '0;
        case (op)
            OP_MUL:                        res = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  res = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               res = bz ? '1 : (nres ? (~q + 1'b1) : q);
            OP_REM, OP_REMU:               res = bz ? a : (nrem ? (~r + 1'b1) : r);
            default:                       res = '0;
        endcase
        return res;
    endfunction

    assign accept    = (state == IDLE) && in_valid && !kill;
    assign is_multi  = (alu_op >= OP_MUL) && (alu_op <= OP_REMU);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    assign sgn_a = (alu_op == OP_MULH) || (alu_op == OP_MULHSU) ||
                   (alu_op == OP_DIV)  || (alu_op == OP_REM);
    assign sgn_b = (alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign mag_a = magnitude(dataA, sgn_a);
    assign mag_b = magnitude(dataB, sgn_b);

    // One multiply step and one restoring-divide step, computed every cycle.
    assign acc_step  = mplier[0] ? (acc + mcand) : acc;
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, divisor});
    assign rem_step  = rem_ge ? (rem_shift[WIDTH-1:0] - divisor) : rem_shift[WIDTH-1:0];
    assign quo_step  = {quo[WIDTH-2:0], rem_ge};

    assign simple_res = simple_op(alu_op, dataA, dataB);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and handshake outputs; kill overrides every transition.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) next_state = is_multi ? BUSY : DONE;
            end
            BUSY: begin
                if (last_iter) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (kill) next_state = IDLE;
    end

    // Iteration counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            result <= '0;
            bool   <= 1'b0;
            op_err <= 1'b0;
        end else begin
            if (kill || accept) begin
                cnt <= '0;
            end else if (state == BUSY) begin
                cnt <= last_iter ? '0 : cnt + 1'b1;
            end
            if (accept && !is_multi) begin
                result <= simple_res[WIDTH-1:0];
                bool   <= simple_res[WIDTH];
                op_err <= (alu_op > OP_REMU);
            end else if ((state == BUSY) && last_iter && !kill) begin
                result <= finish_op(op_q, acc_step, quo_step, rem_step,
                                    neg_res, neg_rem, b_zero, a_q);
                bool   <= 1'b0;
                op_err <= 1'b0;
            end
        end
    end

    // Operand capture on accept, then one multiply and divide bit per BUSY cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= alu_op;
            a_q     <= dataA;
            b_zero  <= (dataB == '0);
            neg_res <= (sgn_a & dataA[WIDTH-1]) ^ (sgn_b & dataB[WIDTH-1]);
            neg_rem <= sgn_a & dataA[WIDTH-1];
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            mplier  <= mag_b;
            rem     <= '0;
            quo     <= mag_a;
            divisor <= mag_b;
        end else if (state == BUSY) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_step;
            quo    <= quo_step;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed testbench for multicycle_alu at WIDTH=32.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_op;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        bool_o;
    logic        op_err;

    int errors = 0;
    int checks = 0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .dataA     (dataA),
        .dataB     (dataB),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .bool      (bool_o),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    // Present a request; returns 1 time unit after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_op   = op;
        dataA    = a;
        dataB    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Edges from accept (accept edge = 1) until out_valid; gives up at 100.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        issue(5'h16, 32'd5, 32'd6);
        wait_valid(lat);
        checks++;
        if (result !== 32'd11 || op_err !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: result=%h op_err=%b expected 0000000b 1", result, op_err);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 00000000", result);
        end
        checks++;
        if (bool_o !== 1'b0 || op_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: bool=%b op_err=%b expected 0 0", bool_o, op_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_simple();
        logic [4:0]  ops  [17] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                   5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h16, 5'h1F, 5'h00};
        logic [31:0] va   [17] = '{32'd3, 32'd3, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                   32'd1, 32'h80000000, 32'h80000000, 32'd5, 32'd5,
                                   32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] vb   [17] = '{32'd4, 32'd5, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                                   32'h21, 32'd4, 32'h24, 32'd5, 32'd5, 32'd1, 32'd2,
                                   32'd1, 32'd1, 32'd3, 32'd1, 32'd1};
        logic [31:0] vres [17] = '{32'd7, 32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                                   32'd2, 32'h08000000, 32'hF8000000, 32'd0, 32'd0, 32'd0, 32'd0,
                                   32'd1, 32'd0, 32'd5, 32'd0, 32'd0};
        logic        vbool[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
        logic        verr [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        logic        vchk [17] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        int lat;
        for (int i = 0; i < 17; i++) begin
            issue(ops[i], va[i], vb[i]);
            wait_valid(lat);
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL simple[%0d] latency: got %0d expected 1", i, lat);
            end
            if (vchk[i]) begin
                checks++;
                if (result !== vres[i]) begin
                    errors++;
                    $display("FAIL simple[%0d] result: got %h expected %h", i, result, vres[i]);
                end
            end
            checks++;
            if (bool_o !== vbool[i] || op_err !== verr[i]) begin
                errors++;
                $display("FAIL simple[%0d] flags: bool=%b op_err=%b expected %b %b",
                         i, bool_o, op_err, vbool[i], verr[i]);
            end
            consume();
        end
    endtask

    task automatic test_multi();
        logic [4:0]  ops  [20] = '{5'h0E, 5'h0F, 5'h11, 5'h10, 5'h0F, 5'h11,
                                   5'h12, 5'h14, 5'h13, 5'h15, 5'h12, 5'h14,
                                   5'h13, 5'h15, 5'h12, 5'h14, 5'h12, 5'h14, 5'h13, 5'h15};
        logic [31:0] va   [20] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                                   32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                   32'd7, 32'hFFFFFFF9, 32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] vb   [20] = '{32'd3, 32'd2, 32'd2, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd2, 32'd2,
                                   32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFE,
                                   32'd16, 32'd16};
        logic [31:0] vres [20] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF,
                                   32'h3FFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'h00000000,
                                   32'hFFFFFFFF, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                   32'd14, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                   32'hFFFFFFFD, 32'd1, 32'h0FFFFFFF, 32'h0000000F};
        int lat;
        for (int i = 0; i < 20; i++) begin
            issue(ops[i], va[i], vb[i]);
            wait_valid(lat);
            checks++;
            if (lat !== 33) begin
                errors++;
                $display("FAIL multi[%0d] latency: got %0d expected 33", i, lat);
            end
            checks++;
            if (result !== vres[i]) begin
                errors++;
                $display("FAIL multi[%0d] result: got %h expected %h", i, result, vres[i]);
            end
            checks++;
            if (bool_o !== 1'b0 || op_err !== 1'b0) begin
                errors++;
                $display("FAIL multi[%0d] flags: bool=%b op_err=%b expected 0 0", i, bool_o, op_err);
            end
            consume();
        end
    endtask

    task automatic test_hold();
        int lat;
        issue(5'h00, 32'd3, 32'd4);
        wait_valid(lat);
        alu_op   = 5'h01;
        dataA    = 32'd10;
        dataB    = 32'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd7 ||
                bool_o !== 1'b0 || op_err !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: out_valid=%b in_ready=%b result=%h expected 1 0 00000007",
                         i, out_valid, in_ready, result);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_transfer: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd8) begin
            errors++;
            $display("FAIL hold_next_accept: out_valid=%b result=%h expected 1 00000008", out_valid, result);
        end
        consume();
    endtask

    task automatic test_kill();
        int lat;
        int seen;
        issue(5'h13, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_busy: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL kill_no_valid: got %0d valid cycles expected 0", seen);
        end
        alu_op   = 5'h00;
        dataA    = 32'd1;
        dataB    = 32'd1;
        in_valid = 1'b1;
        kill     = 1'b1;
        @(posedge clk);
        #1;
        kill     = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL kill_blocks_accept: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        issue(5'h00, 32'd1, 32'd2);
        wait_valid(lat);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL kill_done: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        issue(5'h00, 32'd3, 32'd4);
        wait_valid(lat);
        checks++;
        if (lat !== 1 || result !== 32'd7) begin
            errors++;
            $display("FAIL kill_after_add: latency=%0d result=%h expected 1 00000007", lat, result);
        end
        consume();
    endtask

    task automatic test_reset_busy();
        int lat;
        int seen;
        issue(5'h0E, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_now: out_valid=%b expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_no_valid: valid cycles=%0d in_ready=%b expected 0 1", seen, in_ready);
        end
        issue(5'h00, 32'd3, 32'd4);
        wait_valid(lat);
        checks++;
        if (lat !== 1 || result !== 32'd7) begin
            errors++;
            $display("FAIL rst_busy_add: latency=%0d result=%h expected 1 00000007", lat, result);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(5'h11, 32'hFFFFFFFF, 32'd2);
        wait_valid(lat);
        checks++;
        if (lat !== 33 || result !== 32'd1) begin
            errors++;
            $display("FAIL b2b_mulhu: latency=%0d result=%h expected 33 00000001", lat, result);
        end
        consume();
        issue(5'h00, 32'd10, 32'd20);
        wait_valid(lat);
        checks++;
        if (lat !== 1 || result !== 32'd30) begin
            errors++;
            $display("FAIL b2b_add: latency=%0d result=%h expected 1 0000001e", lat, result);
        end
        consume();
        issue(5'h12, 32'd100, 32'hFFFFFFF9);
        wait_valid(lat);
        checks++;
        if (lat !== 33 || result !== 32'hFFFFFFF2) begin
            errors++;
            $display("FAIL b2b_div: latency=%0d result=%h expected 33 fffffff2", lat, result);
        end
        consume();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_op    = 5'h00;
        dataA     = 32'd0;
        dataB     = 32'd0;
        kill      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_simple();
        test_multi();
        test_hold();
        test_kill();
        test_reset_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
